// File: rtl/opcx_cpu.sv
// opcx_cpu: predicated load/store CPU, NREGS registers (r0 reads zero, top register is the PC), 1/2-word instructions.
// Define OPCX_ROR_EN to make opcode 9 rotate-right-through-carry; without it opcode 9 is a NOP.
module opcx_cpu #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset_b,
    inout  wire  [WIDTH-1:0] data,
    output logic [WIDTH-1:0] address,
    output logic             rnw
);
    localparam int RW = $clog2(NREGS);
    localparam logic [RW-1:0] PC_IDX = RW'(NREGS - 1);
    typedef enum logic [2:0] {FETCH0, FETCH1, EA_ED, RDMEM, EXEC, WRMEM} state_t;
    state_t state_q, state_d;
    logic [2:0] pred_q, pred_d;
    logic [3:0] opc_q, opc_d;
    logic [RW-1:0] src_q, src_d, dst_q, dst_d;
    logic [WIDTH-1:0] or_q, or_d, pc_q, pc_d;
    logic c_q, c_d, z_q, z_d;
    logic [WIDTH-1:0] gpr_q [NREGS];
    logic [WIDTH-1:0] src_val, dst_val, res;
    logic [WIDTH:0] sum;
    logic [7:0] pred_tab;
    logic pred_ok, cin, res_c, writes, wr_en, drive;
    // The PC register always holds the address after the current instruction once fetch is done
    assign src_val = src_q == '0 ? '0 : src_q == PC_IDX ? pc_q : gpr_q[src_q];
    assign dst_val = dst_q == '0 ? '0 : dst_q == PC_IDX ? pc_q : gpr_q[dst_q];
    assign pred_tab = {1'b0, !c_q || z_q, c_q && !z_q, !c_q, c_q, !z_q, z_q, 1'b1};
    assign pred_ok = pred_tab[pred_q];
    assign data = drive ? dst_val : {WIDTH{1'bz}};
    always_ff @(posedge clk) begin
        if (!reset_b)
            state_q <= FETCH0;
        else
            state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH0: state_d = data[12] ? FETCH1 : EA_ED;
            FETCH1: state_d = EA_ED;
            EA_ED: state_d = !pred_ok ? FETCH0 : opc_q == 4'd7 ? RDMEM : opc_q == 4'd8 ? WRMEM : EXEC;
            RDMEM: state_d = EXEC;
            default: state_d = FETCH0;
        endcase
    end
    always_comb begin
        drive = state_q == WRMEM;
        rnw = !drive;
        address = (state_q == RDMEM || drive) ? or_q : pc_q;
    end
    // In EXEC or_q holds EA, or the loaded word for ld
    always_comb begin
        cin = opc_q == 4'd3 || (opc_q == 4'd2 && c_q);
        sum = {1'b0, dst_val} + {1'b0, opc_q == 4'd3 ? ~or_q : or_q} + {{WIDTH{1'b0}}, cin};
        res = or_q;
        res_c = c_q;
        writes = 1'b1;
        case (opc_q)
            4'd0, 4'd7: res = or_q;
            4'd1, 4'd2, 4'd3: {res_c, res} = sum;
            4'd4: res = dst_val & or_q;
            4'd5: res = dst_val | or_q;
            4'd6: res = dst_val ^ or_q;
`ifdef OPCX_ROR_EN
            4'd9: {res_c, res} = {or_q[0], c_q, or_q[WIDTH-1:1]};
`endif
            default: writes = 1'b0;
        endcase
    end
    always_comb begin
        pred_d = pred_q;
        opc_d = opc_q;
        src_d = src_q;
        dst_d = dst_q;
        or_d = or_q;
        pc_d = pc_q;
        c_d = c_q;
        z_d = z_q;
        wr_en = 1'b0;
        case (state_q)
            FETCH0: begin
                pred_d = data[15:13];
                opc_d = data[11:8];
                src_d = data[4 +: RW];
                dst_d = data[0 +: RW];
                or_d = '0;
                pc_d = pc_q + WIDTH'(1);
            end
            FETCH1: begin
                or_d = data;
                pc_d = pc_q + WIDTH'(1);
            end
            EA_ED: or_d = src_val + or_q;
            RDMEM: or_d = data;
            EXEC: begin
                c_d = res_c;
                z_d = writes ? res == '0 : z_q;
                pc_d = (writes && dst_q == PC_IDX) ? res : pc_q;
                wr_en = writes && dst_q != '0 && dst_q != PC_IDX;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            pc_q <= '0;
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            c_q <= c_d;
            z_q <= z_d;
        end
        pred_q <= pred_d;
        opc_q <= opc_d;
        src_q <= src_d;
        dst_q <= dst_d;
        or_q <= or_d;
    end
    always_ff @(posedge clk) begin
        if (reset_b && wr_en)
            gpr_q[dst_q] <= res;
    end
endmodule

// File: tb/tb_opcx_cpu.sv
// tb_opcx_cpu: builds a directed program, predicts each memory write (address, data, cycle) into a queue,
// and a negedge monitor pops and compares every write the CPU performs.
module tb_opcx_cpu;
    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        int c;
    } exp_t;
`ifdef OPCX_ROR_EN
    localparam bit ROR = 1'b1;
`else
    localparam bit ROR = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_b = 1'b0;
    wire [15:0] data, data2;
    logic [15:0] address, address2;
    logic rnw, rnw2;
    logic [15:0] mem [65536];
    logic [15:0] mem2 [32];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t = 0;
    int jump_cyc = -1;
    logic [15:0] bpc = '0;

    opcx_cpu #(.WIDTH(16), .NREGS(16)) dut (.clk(clk), .reset_b(reset_b), .data(data), .address(address), .rnw(rnw));
    opcx_cpu #(.WIDTH(16), .NREGS(8)) dut8 (.clk(clk), .reset_b(reset_b), .data(data2), .address(address2), .rnw(rnw2));

    always #5 clk = ~clk;
    assign data = rnw ? mem[address] : 'z;
    assign data2 = rnw2 ? mem2[address2[4:0]] : 'z;
    always @(posedge clk) cyc <= reset_b ? cyc + 1 : 0;
    always @(posedge clk) if (rnw === 1'b0) mem[address] <= data;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rnw === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stray_write: addr %h data %h cycle %0d, no write expected", address, data, cyc);
            end else begin
                e = sb.pop_front();
                if (address !== e.a || data !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h cycle %0d, expected addr %h data %h cycle %0d",
                             address, data, cyc, e.a, e.d, e.c);
                end
            end
        end
        if (cyc == jump_cyc) chk("jump_fetch", address, 16'h0040);
        if (reset_b && cyc == 4 && jump_cyc >= 0) chk("nregs8_pc_dst", address2, 16'h0010);
    end

    // Place one instruction and advance the cycle model by its spec cycle count
    task automatic put(input logic [2:0] p, input logic [3:0] op, input logic [3:0] s, input logic [3:0] d,
                       input logic ln, input logic [15:0] opnd, input bit taken,
                       input logic [15:0] wa, input logic [15:0] wd);
        int n;
        exp_t e;
        mem[bpc] = {p, ln, op, s, d};
        if (ln) mem[bpc + 16'd1] = opnd;
        n = (taken ? (op == 4'd7 ? 4 : 3) : 2) + (ln ? 1 : 0);
        if (taken && op == 4'd8) begin
            e.a = wa;
            e.d = wd;
            e.c = t + n - 1;
            sb.push_back(e);
        end
        t += n;
        bpc += ln ? 16'd2 : 16'd1;
    endtask
    task automatic alu(input logic [3:0] op, input logic [3:0] s, input logic [3:0] d, input logic ln, input logic [15:0] opnd);
        put(3'd0, op, s, d, ln, opnd, 1'b1, 16'h0, 16'h0);
    endtask
    task automatic mark(input logic [2:0] p, input logic [15:0] wa, input bit taken);
        put(p, 4'd8, 4'd0, 4'd15, 1'b1, wa, taken, wa, bpc + 16'd2);
    endtask
    task automatic st(input logic [3:0] d, input logic [15:0] wa, input logic [15:0] wd);
        put(3'd0, 4'd8, 4'd0, d, 1'b1, wa, 1'b1, wa, wd);
    endtask

    task automatic build;
        mark(3'd1, 16'h0300, 1'b0);
        mark(3'd2, 16'h0301, 1'b1);
        mark(3'd3, 16'h0302, 1'b0);
        mark(3'd4, 16'h0303, 1'b1);
        alu(4'd0, 4'd0, 4'd15, 1'b1, 16'h0040);
        jump_cyc = t;
        bpc = 16'h0040;
        alu(4'd0, 4'd15, 4'd7, 1'b0, 16'h0);
        st(4'd7, 16'h031D, 16'h0041);
        alu(4'd0, 4'd0, 4'd3, 1'b1, 16'h5555);
        alu(4'd0, 4'd0, 4'd2, 1'b1, 16'h0005);
        alu(4'd0, 4'd0, 4'd1, 1'b1, 16'hFFFF);
        alu(4'd1, 4'd0, 4'd1, 1'b1, 16'h0001);
        st(4'd1, 16'h0304, 16'h0000);
        mark(3'd1, 16'h0305, 1'b1);
        mark(3'd3, 16'h0306, 1'b1);
        mark(3'd5, 16'h0307, 1'b0);
        mark(3'd6, 16'h0308, 1'b1);
        put(3'd2, 4'd0, 4'd0, 4'd3, 1'b1, 16'h1234, 1'b0, 16'h0, 16'h0);
        st(4'd3, 16'h0309, 16'h5555);
        alu(4'd2, 4'd0, 4'd2, 1'b0, 16'h0);
        st(4'd2, 16'h030A, 16'h0006);
        mark(3'd3, 16'h030B, 1'b0);
        mark(3'd4, 16'h030C, 1'b1);
        mark(3'd1, 16'h030D, 1'b0);
        mark(3'd2, 16'h030E, 1'b1);
        mark(3'd5, 16'h030F, 1'b0);
        alu(4'd3, 4'd0, 4'd2, 1'b1, 16'h0006);
        mark(3'd1, 16'h0310, 1'b1);
        mark(3'd3, 16'h0311, 1'b1);
        alu(4'd3, 4'd0, 4'd2, 1'b1, 16'h0001);
        st(4'd2, 16'h0312, 16'hFFFF);
        mark(3'd4, 16'h0313, 1'b1);
        alu(4'd0, 4'd0, 4'd8, 1'b1, 16'h0F0F);
        alu(4'd4, 4'd0, 4'd8, 1'b1, 16'h00FF);
        st(4'd8, 16'h0314, 16'h000F);
        alu(4'd5, 4'd0, 4'd8, 1'b1, 16'hF000);
        st(4'd8, 16'h0315, 16'hF00F);
        alu(4'd6, 4'd0, 4'd8, 1'b1, 16'hFFFF);
        st(4'd8, 16'h0316, 16'h0FF0);
        alu(4'd0, 4'd0, 4'd4, 1'b1, 16'h0100);
        alu(4'd0, 4'd0, 4'd5, 1'b1, 16'hBEEF);
        put(3'd0, 4'd8, 4'd4, 4'd5, 1'b1, 16'h0002, 1'b1, 16'h0102, 16'hBEEF);
        alu(4'd7, 4'd4, 4'd6, 1'b1, 16'h0002);
        st(4'd6, 16'h0317, 16'hBEEF);
        alu(4'd7, 4'd0, 4'd9, 1'b1, 16'h0200);
        mark(3'd1, 16'h0318, 1'b1);
        alu(4'd9, 4'd0, 4'd1, 1'b1, 16'h0003);
        st(4'd1, 16'h0319, ROR ? 16'h0001 : 16'h0000);
        mark(3'd3, 16'h031A, ROR);
        mark(3'd4, 16'h031B, !ROR);
        mark(3'd1, 16'h031C, !ROR);
        alu(4'd0, 4'd0, 4'd11, 1'b1, 16'h031E);
        mark(3'd7, 16'h031F, 1'b0);
        alu(4'd0, 4'd0, 4'd15, 1'b1, 16'hFFFF);
        bpc = 16'hFFFF;
        put(3'd0, 4'd8, 4'd11, 4'd15, 1'b0, 16'h0, 1'b1, 16'h031E, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < 32; i++) mem2[i] = '0;
        mem[0] = {3'd0, 1'b1, 4'd7, 4'd0, 4'd6};
        mem[1] = 16'h0200;
        mem2[0] = {3'd0, 1'b1, 4'd0, 4'd0, 4'd15};
        mem2[1] = 16'h0010;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ld_rdmem_addr", address, 16'h0200);
        reset_b = 1'b0;
        build();
        @(posedge clk);
        @(negedge clk);
        chk("reset_addr", address, 16'h0000);
        chk("reset_rnw", {15'd0, rnw}, 16'h0001);
        chk("reset_bus", data, mem[0]);
        @(posedge clk);
        @(negedge clk) reset_b = 1'b1;
        for (int i = 0; i < 3000 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d expected writes never seen", sb.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/opcx_cpu.md
# opcx_cpu

Parametrised next-generation OPC accumulator-free load/store CPU core: register file of configurable depth, configurable data/address width, variable-length (1- or 2-word) instructions, 3-bit predicate field and an extended ALU (carry-in add, subtract, logic, optional rotate). Sits at the top of the processor subsystem and connects directly to an asynchronous-read memory over a shared bidirectional data bus.

## Interface

- WIDTH, 16: data, address and register width; must be >= 16; instruction fields occupy data[15:0], upper bits ignored in IR
- NREGS, 16: register count, power of 2, 4..16; register 0 reads as zero, register NREGS-1 is the PC
- clk  input  1  rising-edge clock
- reset_b  input  1  reset; synchronous, active-low
- data  inout  WIDTH  memory data; driven only in WRMEM, else high-Z
- address  output  WIDTH  memory address
- rnw  output  1  1 = read, 0 = write (low only in WRMEM)

## Operation

- Instruction word: [15:13] predicate, [12] LEN (1 = operand word follows), [11:8] opcode, [7:4] src, [3:0] dst; src/dst masked to log2(NREGS) bits.
- Predicates: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 C&!Z, 6 !C|Z, 7 never.
- Operand OP = second word if LEN=1, else 0. EA = R[src] + OP (mod 2^WIDTH).
- Opcodes (result written to R[dst] unless noted): 0 mov: EA; 1 add: R[dst]+EA, C=carry; 2 adc: R[dst]+EA+C, C=carry; 3 sub: R[dst]+~EA+1, C=carry (1 = no borrow); 4 and; 5 or; 6 xor (R[dst] op EA); 7 ld: mem[EA]; 8 sto: mem[EA] <= R[dst], no reg/flag write; 9 ror: {C,result} <= {EA[0], C, EA[WIDTH-1:1]} (see Configuration); 10-15 NOP.
- Z <= (result==0) for opcodes 0-7 and 9; C changed only by 1,2,3,9; flags unchanged by sto, NOP, skipped instructions.
- Write to R[0] discarded. Write to PC: PC <= result, next fetch from result.
- Reading PC as src or dst yields address of the word following the current instruction (after operand, if any).
- FSM states: FETCH0 (IR <= data, PC++), FETCH1 (OR <= data, PC++), EA_ED (OR <= EA, predicate evaluated), RDMEM (OR <= data), EXEC (write back), WRMEM (drive data).
- Transitions: FETCH0 -> FETCH1 if data[12] else EA_ED; FETCH1 -> EA_ED; EA_ED -> FETCH0 if predicate false, RDMEM if ld, WRMEM if sto, else EXEC; RDMEM -> EXEC; EXEC, WRMEM -> FETCH0.
- address = OR in RDMEM/WRMEM, PC otherwise.

## Timing

- Reset (reset_b low at a rising edge): FSM=FETCH0, PC=0, C=0, Z=0; outputs next cycle: address=0, rnw=1, data high-Z. GPRs not reset. Reset mid-instruction aborts it; no register/memory write occurs in the reset cycle.
- Memory read is combinational; data sampled on the rising edge ending FETCH0/FETCH1/RDMEM.
- Cycle counts: ALU/mov 3 (LEN=0) / 4 (LEN=1); ld 4/5; sto 3/4; predicate-false 2/3.
- Register write and flag update take effect on the edge ending EXEC; visible to the next instruction's EA_ED.
- PC increment in FETCH0/FETCH1 wraps 2^WIDTH-1 -> 0.

## Configuration

- OPCX_ROR_EN: defined -> opcode 9 is rotate-right-through-carry as above. Undefined -> opcode 9 is a NOP (3/4 cycles, no register or flag change) and the rotate logic is not synthesised.

## Test plan

- Reset: hold reset_b low 2 cycles mid-ld -> address=0, rnw=1, data high-Z; first fetch from 0x0000, C=Z=0.
- Arithmetic: mov r1,#0xFFFF; add r1,#1 -> r1=0, C=1, Z=1; adc r2,r0 (r2=5) -> r2=6, C=1->carry 0, Z=0.
- Predication: with Z=1, 2-word "!Z mov r3,#0x1234" -> r3 unchanged, 3 cycles, PC advanced by 2.
- Memory: mov r4,#0x0100; sto r5 (=0xBEEF),r4,#2 -> write 0xBEEF at 0x0102, rnw=0 one cycle; ld r6,r4,#2 -> r6=0xBEEF.
- Control flow: mov pc,r0,#0x0040 -> next FETCH0 address=0x0040; mov r7,pc at 0x0040 (1-word) -> r7=0x0041.
- Config/params: ror r1,#0x0003 with C=0 -> OPCX_ROR_EN: r1=0x0001, C=1; undefined: r1, C unchanged. NREGS=8: dst field 0xF addresses PC (r7).
